cell_reveal_engine: RTL and testbench
=====================================

// Module: cell_reveal_engine
// PURPOSE
//  Minesweeper dig/flood-fill engine: takes the cursor position from moverse and
//  the per-cell counts from contarBombas (bomb = BOMB_CODE), maintains the revealed
//  mask consumed by VGA, and flags game over / win. Sits between contarBombas/moverse
//  and VGA inside gameLogic. Zero cells expand iteratively via an internal index stack.
// PARAMETERS
//  N          8      grid side in cells (power of 2, 2..8); cell index i = y*N + x
//  BOMB_CODE  4'd9   cell_val code marking a bomb
// PORTS
//  clk          in   1       system clock
//  rst          in   1       async reset, active-low
//  cell_val     in   4*N*N   cell i count at [4*i +: 4]; stable while busy
//  num_bombs    in   6       bombs on board; used for win detection
//  pos_x        in   log2N   cursor column
//  pos_y        in   log2N   cursor row
//  dig          in   1       1-cycle pulse: reveal cell (pos_x,pos_y)
//  new_game     in   1       1-cycle pulse: synchronous clear of all state
//  revealed     out  N*N     bit i = cell i revealed
//  rev_count    out  7       number of revealed cells
//  busy         out  1       engine processing a dig
//  done         out  1       1-cycle pulse when a dig completes
//  game_over    out  1       sticky; bomb revealed
//  win          out  1       sticky; all non-bomb cells revealed
// BEHAVIOUR
//  - Reset (rst=0, async): revealed=0, rev_count=0, busy=0, done=0, game_over=0,
//    win=0, stack pointer=0, state IDLE. new_game: same values next edge, any state.
//  - FSM IDLE -> CHECK -> (POP -> SCAN x8)* -> FIN -> IDLE.
//  - IDLE: dig accepted only if !game_over && !win; latches idx=pos_y*N+pos_x.
//    busy=1 from next cycle until FIN inclusive; dig ignored while busy.
//  - CHECK: already revealed (or flagged, FLAG_EN) -> FIN, no change. Bomb -> set
//    bit, game_over=1 -> FIN. Else set bit, rev_count+1; if value 0 push idx; -> POP.
//  - POP: stack empty -> FIN; else pop into cur, -> SCAN with dir=0.
//  - SCAN: one neighbour per cycle, dir 0..7 = N,NE,E,SE,S,SW,W,NW. Out-of-bounds
//    (row/col <0 or >N-1; no wrap) skipped. In-bounds, unrevealed, unflagged, not
//    bomb: set bit, rev_count+1; push if value 0. After dir 7 -> POP.
//  - Cell bit is set before push: each cell pushed at most once; stack depth N*N
//    never overflows. Bombs never revealed by flood.
//  - FIN: done=1 one cycle; win=1 if rev_count==N*N-num_bombs and !game_over.
//  - Latency: non-zero safe cell: dig at edge k, bit visible k+2, done at k+4.
//  - new_game coincident with dig: new_game wins, dig dropped. new_game mid-flood
//    aborts, stack cleared.
//  - rev_count saturates never (max N*N=64 fits 7 bits).
// CONFIGURATION
//  CELL_FLAG_EN defined: adds input flag (1-cycle pulse, toggles flag on cell
//   (pos_x,pos_y) when IDLE and cell unrevealed; ignored otherwise) and output
//   flagged[N*N]. Flagged cells not revealed by dig or flood; flag cleared by reset
//   and new_game. flag and dig same cycle: dig wins.
//  Not defined: no flag port/output; all unrevealed cells eligible.
// TESTING
//  1 Board all 1s except bomb at 0, dig (3,3) -> bit 27 set, rev_count=1, done at k+4.
//  2 Bomb at (5,2), dig there -> bit 21 set, game_over=1; later dig ignored.
//  3 Single bomb at (7,7) with counts, dig (0,0) -> revealed=all but bit 63,
//    rev_count=63, win=1, busy fell once.
//  4 Corner zero at (0,0) only, neighbours 1 -> bits 0,1,8,9 set, no wrap bits 7/56.
//  5 dig mid-flood of test 3 -> ignored; new_game mid-flood -> all outputs 0 next edge.
//  6 CELL_FLAG_EN: flag (1,0) then dig (0,0) of test 4 -> bit 1 clear, rev_count=3.

Source files
------------

// File: rtl/cell_reveal_engine.sv
// Minesweeper dig / flood-fill engine: maintains the revealed mask, the reveal count and game over / win.
// Optional per-cell flagging is compiled in when CELL_FLAG_EN is defined.
module cell_reveal_engine #(
  parameter int         N         = 8,
  parameter logic [3:0] BOMB_CODE = 4'd9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*N*N-1:0]     cell_val,
  input  logic [5:0]           num_bombs,
  input  logic [$clog2(N)-1:0] pos_x,
  input  logic [$clog2(N)-1:0] pos_y,
  input  logic                 dig,
  input  logic                 new_game,
`ifdef CELL_FLAG_EN
  input  logic                 flag,
  output logic [N*N-1:0]       flagged,
`endif
  output logic [N*N-1:0]       revealed,
  output logic [6:0]           rev_count,
  output logic                 busy,
  output logic                 done,
  output logic                 game_over,
  output logic                 win
);

  // state | meaning
  // IDLE  | waiting for a dig (or a flag toggle)
  // CHECK | evaluate the dug cell itself
  // POP   | take the next zero cell off the stack, or finish when empty
  // SCAN  | visit one neighbour of cur per cycle, dir 0..7 = N,NE,E,SE,S,SW,W,NW
  // FIN   | dig complete; done and win are registered on the way out

  localparam int IW  = $clog2(N);
  localparam int XW  = 2 * IW;
  localparam int NN  = N * N;
  localparam int SPW = $clog2(NN + 1);
  localparam logic [IW+1:0] ONE = (IW+2)'(1);
  localparam logic [IW+1:0] NEG = '1;

  typedef enum logic [2:0] {IDLE, CHECK, POP, SCAN, FIN} state_t;

  state_t          state, nxt;
  logic [XW-1:0]   idx, cur, tidx, nidx, pidx, top_idx;
  logic [2:0]      dir;
  logic [SPW-1:0]  sp;
  logic [IW+1:0]   dx, dy, nx, ny;
  logic [3:0]      tval;
  logic [NN-1:0]   flag_mask;
  logic            inb, t_free, t_bomb, t_zero, accept, win_hit;
  logic            set_bit, inc_cnt, push, pop, set_go;
  logic [XW-1:0]   stack [NN];

  assign pidx    = {pos_y, pos_x};
  assign busy    = (state != IDLE);
  assign top_idx = XW'(sp - SPW'(1));
  assign win_hit = (rev_count == (7'(NN) - {1'b0, num_bombs})) && !game_over;

`ifdef CELL_FLAG_EN
  assign flag_mask = flagged;
`else
  assign flag_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          state <= IDLE;
    else if (new_game) state <= IDLE;
    else               state <= nxt;
  end

  always_comb begin
    nxt     = state;
    set_bit = 1'b0;
    inc_cnt = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    set_go  = 1'b0;
    dx      = '0;
    dy      = '0;
    case (dir)
      3'd0: dy = NEG;
      3'd1: begin dx = ONE; dy = NEG; end
      3'd2: dx = ONE;
      3'd3: begin dx = ONE; dy = ONE; end
      3'd4: dy = ONE;
      3'd5: begin dx = NEG; dy = ONE; end
      3'd6: dx = NEG;
      default: begin dx = NEG; dy = NEG; end
    endcase
    // Two guard bits catch both -1 and N without any wrap onto the next row.
    nx     = {2'b00, cur[IW-1:0]} + dx;
    ny     = {2'b00, cur[XW-1:IW]} + dy;
    inb    = (nx[IW+1:IW] == 2'b00) && (ny[IW+1:IW] == 2'b00);
    nidx   = {ny[IW-1:0], nx[IW-1:0]};
    tidx   = (state == SCAN) ? nidx : idx;
    tval   = cell_val[{tidx, 2'b00} +: 4];
    t_bomb = (tval == BOMB_CODE);
    t_zero = (tval == 4'd0);
    t_free = !revealed[tidx] && !flag_mask[tidx];
    accept = dig && !game_over && !win;
    case (state)
      IDLE: if (accept) nxt = CHECK;
      CHECK: begin
        if (!t_free) begin
          nxt = FIN;
        end else if (t_bomb) begin
          set_bit = 1'b1;
          set_go  = 1'b1;
          nxt     = FIN;
        end else begin
          set_bit = 1'b1;
          inc_cnt = 1'b1;
          push    = t_zero;
          nxt     = POP;
        end
      end
      POP: begin
        if (sp == '0) begin
          nxt = FIN;
        end else begin
          pop = 1'b1;
          nxt = SCAN;
        end
      end
      SCAN: begin
        if (inb && t_free && !t_bomb) begin
          set_bit = 1'b1;
          inc_cnt = 1'b1;
          push    = t_zero;
        end
        if (dir == 3'd7) nxt = POP;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      revealed  <= '0;
      rev_count <= '0;
      done      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
      sp        <= '0;
      idx       <= '0;
      cur       <= '0;
      dir       <= '0;
    end else if (new_game) begin
      revealed  <= '0;
      rev_count <= '0;
      done      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
      sp        <= '0;
      idx       <= '0;
      cur       <= '0;
      dir       <= '0;
    end else begin
      done <= (state == FIN);
      if (state == IDLE && accept) idx <= pidx;
      if (state == POP)       dir <= '0;
      else if (state == SCAN) dir <= dir + 3'd1;
      if (set_bit) revealed[tidx] <= 1'b1;
      if (inc_cnt) rev_count <= rev_count + 7'd1;
      if (set_go)  game_over <= 1'b1;
      if (push) begin
        sp <= sp + SPW'(1);
      end else if (pop) begin
        sp  <= sp - SPW'(1);
        cur <= stack[top_idx];
      end
      if (state == FIN && win_hit) win <= 1'b1;
    end
  end

  // Each cell is marked revealed in the same cycle it is pushed, so depth NN is never exceeded.
  always_ff @(posedge clk) begin
    if (push) stack[sp[XW-1:0]] <= tidx;
  end

`ifdef CELL_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flagged <= '0;
    else if (new_game)
      flagged <= '0;
    else if (state == IDLE && flag && !dig && !revealed[pidx])
      flagged[pidx] <= !flagged[pidx];
  end
`endif

endmodule

// File: tb/tb_cell_reveal_engine.sv
// Self-checking bench for cell_reveal_engine: table of digs on prepared boards plus flood corner cases.
module tb_cell_reveal_engine;
  localparam int N  = 8;
  localparam int NN = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [4*NN-1:0]   cell_val;
  logic [5:0]        num_bombs;
  logic [2:0]        pos_x, pos_y;
  logic              dig, new_game;
  logic [NN-1:0]     revealed;
  logic [6:0]        rev_count;
  logic              busy, done, game_over, win;
`ifdef CELL_FLAG_EN
  logic              flag;
  logic [NN-1:0]     flagged;
`endif

  always #5 clk = ~clk;

  cell_reveal_engine #(.N(N), .BOMB_CODE(4'd9)) dut (
    .clk(clk), .rst(rst), .cell_val(cell_val), .num_bombs(num_bombs),
    .pos_x(pos_x), .pos_y(pos_y), .dig(dig), .new_game(new_game),
`ifdef CELL_FLAG_EN
    .flag(flag), .flagged(flagged),
`endif
    .revealed(revealed), .rev_count(rev_count), .busy(busy), .done(done),
    .game_over(game_over), .win(win)
  );

  typedef struct {
    logic [63:0] rev;
    logic [6:0]  cnt;
    logic        go;
    logic        w;
  } exp_t;

  typedef struct {
    int   kind;
    int   x;
    int   y;
    exp_t e;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[6];

  // Board kinds: 0 all 1s + bomb at 0; 1 all 1s + bomb at 21; 2 zeros + bomb at 63;
  // 3 all 1s, zero at 0, bomb at 63; 4 all 1s, zero at 7, bomb at 56.
  function automatic logic [4*NN-1:0] board(input int kind);
    logic [4*NN-1:0] b;
    for (int i = 0; i < NN; i++) b[4*i +: 4] = (kind == 2) ? 4'd0 : 4'd1;
    case (kind)
      0: b[4*0 +: 4] = 4'd9;
      1: b[4*21 +: 4] = 4'd9;
      2: begin
        b[4*54 +: 4] = 4'd1;
        b[4*55 +: 4] = 4'd1;
        b[4*62 +: 4] = 4'd1;
        b[4*63 +: 4] = 4'd9;
      end
      3: begin
        b[4*0 +: 4]  = 4'd0;
        b[4*63 +: 4] = 4'd9;
      end
      default: begin
        b[4*7 +: 4]  = 4'd0;
        b[4*56 +: 4] = 4'd9;
      end
    endcase
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic start(input int kind);
    cell_val  = board(kind);
    num_bombs = 6'd1;
    new_game  = 1'b1;
    tick();
    new_game  = 1'b0;
  endtask

  task automatic dig_at(input int x, input int y);
    pos_x = 3'(x);
    pos_y = 3'(y);
    dig   = 1'b1;
    tick();
    dig   = 1'b0;
  endtask

  task automatic wait_done(output int falls, output bit ok);
    bit prev;
    ok    = 1'b0;
    falls = 0;
    prev  = busy;
    for (int c = 0; c < 3000 && !ok; c++) begin
      tick();
      if (prev && !busy) falls++;
      prev = busy;
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    exp_t e;
    int   falls;
    bit   ok;
    start(v.kind);
    sb.push_back(v.e);
    dig_at(v.x, v.y);
    wait_done(falls, ok);
    e = sb.pop_front();
    if (ok) begin
      chk($sformatf("vec%0d_revealed", n), revealed, e.rev);
      chk($sformatf("vec%0d_rev_count", n), rev_count, e.cnt);
      chk($sformatf("vec%0d_game_over", n), game_over, e.go);
      chk($sformatf("vec%0d_win", n), win, e.w);
    end
  endtask

  initial begin
    int  falls;
    bit  ok;
    bit  saw;
    vecs[0] = '{kind: 0, x: 3, y: 3, e: '{rev: 64'h0000_0000_0800_0000, cnt: 7'd1,  go: 1'b0, w: 1'b0}};
    vecs[1] = '{kind: 1, x: 5, y: 2, e: '{rev: 64'h0000_0000_0020_0000, cnt: 7'd0,  go: 1'b1, w: 1'b0}};
    vecs[2] = '{kind: 3, x: 0, y: 0, e: '{rev: 64'h0000_0000_0000_0303, cnt: 7'd4,  go: 1'b0, w: 1'b0}};
    vecs[3] = '{kind: 4, x: 7, y: 0, e: '{rev: 64'h0000_0000_0000_C0C0, cnt: 7'd4,  go: 1'b0, w: 1'b0}};
    vecs[4] = '{kind: 0, x: 0, y: 0, e: '{rev: 64'h0000_0000_0000_0001, cnt: 7'd0,  go: 1'b1, w: 1'b0}};
    vecs[5] = '{kind: 2, x: 0, y: 0, e: '{rev: 64'h7FFF_FFFF_FFFF_FFFF, cnt: 7'd63, go: 1'b0, w: 1'b1}};

    rst = 1'b0; dig = 1'b0; new_game = 1'b0; pos_x = '0; pos_y = '0;
    cell_val = board(0); num_bombs = 6'd1;
`ifdef CELL_FLAG_EN
    flag = 1'b0;
`endif
    #12;
    chk("reset_revealed", revealed, 64'd0);
    chk("reset_flags", {rev_count, busy, done, game_over, win}, 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Latency: dig driven just after edge k -> bit after k+2, done after k+4 only.
    start(0);
    pos_x = 3'd3; pos_y = 3'd3; dig = 1'b1;
    tick(); dig = 1'b0;
    chk("lat_k1_busy", busy, 1'b1);
    chk("lat_k1_bit", revealed[27], 1'b0);
    tick();
    chk("lat_k2_bit", revealed[27], 1'b1);
    chk("lat_k2_done", done, 1'b0);
    tick();
    chk("lat_k3_done", done, 1'b0);
    tick();
    chk("lat_k4_done", done, 1'b1);
    chk("lat_k4_busy", busy, 1'b0);
    tick();
    chk("lat_k5_done", done, 1'b0);

    // After a bomb, further digs are dropped.
    start(1);
    dig_at(5, 2);
    wait_done(falls, ok);
    dig_at(0, 0);
    saw = busy;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) saw = 1'b1;
    end
    chk("go_dig_ignored_busy", saw, 1'b0);
    chk("go_dig_ignored_rev", revealed, 64'h0000_0000_0020_0000);
    chk("go_sticky", game_over, 1'b1);

    // Full flood with a dig on the bomb injected mid-flood.
    start(2);
    dig_at(0, 0);
    ok = 1'b0; falls = 0; saw = busy;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (c == 20) begin pos_x = 3'd7; pos_y = 3'd7; dig = 1'b1; end
      if (c == 21) dig = 1'b0;
      tick();
      if (saw && !busy) falls++;
      saw = busy;
      if (done) ok = 1'b1;
    end
    chk("flood_done_seen", ok, 1'b1);
    chk("flood_revealed", revealed, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("flood_rev_count", rev_count, 7'd63);
    chk("flood_no_go", game_over, 1'b0);
    chk("flood_win", win, 1'b1);
    chk("flood_busy_falls", falls, 1);

    // new_game mid-flood aborts everything at the next edge.
    start(2);
    dig_at(0, 0);
    for (int c = 0; c < 15; c++) tick();
    chk("abort_busy_before", busy, 1'b1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("abort_revealed", revealed, 64'd0);
    chk("abort_flags", {rev_count, busy, done, game_over, win}, 64'd0);
    for (int c = 0; c < 5; c++) tick();
    chk("abort_stays_clear", {revealed[62:0], busy}, 64'd0);

    // new_game coincident with dig: dig is dropped.
    start(0);
    pos_x = 3'd3; pos_y = 3'd3; dig = 1'b1; new_game = 1'b1;
    tick();
    dig = 1'b0; new_game = 1'b0;
    saw = busy;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || done) saw = 1'b1;
    end
    chk("coincident_no_dig", saw, 1'b0);
    chk("coincident_revealed", revealed, 64'd0);

`ifdef CELL_FLAG_EN
    start(3);
    pos_x = 3'd1; pos_y = 3'd0; flag = 1'b1;
    tick();
    flag = 1'b0;
    chk("flag_set", flagged, 64'd2);
    dig_at(0, 0);
    wait_done(falls, ok);
    chk("flag_revealed", revealed, 64'h0000_0000_0000_0301);
    chk("flag_rev_count", rev_count, 7'd3);
    start(3);
    chk("flag_cleared", flagged, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
